// File: rtl/arb_mux_nch_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | arb_mux_nch_if : channel-side and output-side signals of arb_mux_nch      |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface arb_mux_nch_if #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4
);
   localparam int SW = (CHANNELS > 2) ? $clog2(CHANNELS) : 1;

   logic [CHANNELS*WIDTH-1:0] in_data;
   logic [CHANNELS-1:0]       in_valid;
   logic [CHANNELS-1:0]       in_ready;
   logic                      mode;
   logic [SW-1:0]             sel;
   logic [WIDTH-1:0]          out_data;
   logic                      out_valid;
   logic                      out_ready;
   logic [SW-1:0]             out_ch;

   modport master (
      output in_data, in_valid, mode, sel, out_ready,
      input  in_ready, out_data, out_valid, out_ch
   );

   modport slave (
      input  in_data, in_valid, mode, sel, out_ready,
      output in_ready, out_data, out_valid, out_ch
   );
endinterface
`default_nettype wire

// File: rtl/arb_mux_nch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | arb_mux_nch : N-channel fixed/round-robin arbiter into a one-word buffer  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module arb_mux_nch #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4
) (
   input  wire logic          clk_i,
   input  wire logic          rst_i,
   arb_mux_nch_if.slave       arb_if
);
   localparam int              SW          = (CHANNELS > 2) ? $clog2(CHANNELS) : 1;
   localparam logic [SW:0]     c_CH_EXT    = (SW+1)'(CHANNELS);
   localparam logic [SW-1:0]   c_LAST      = SW'(CHANNELS-1);

   logic [WIDTH-1:0]    out_data_q;
   logic [SW-1:0]       out_ch_q;
   logic                out_valid_q;
   logic [SW-1:0]       ptr_q;
   logic [SW-1:0]       w_ptr_d;

   logic                w_gnt_found;
   logic [SW-1:0]       w_gnt_idx;
   logic [CHANNELS-1:0] w_gnt_oh;
   logic [WIDTH-1:0]    w_gnt_data;
   logic [SW:0]         w_rr_sum;
   logic [SW-1:0]       w_rr_idx;
   logic                w_load;

   // Round-robin scan runs from the farthest offset down so the nearest
   // requester to the pointer is the last, and therefore winning, assignment.
   always_comb begin
      w_gnt_found = 1'b0;
      w_gnt_idx   = '0;
      w_rr_sum    = '0;
      w_rr_idx    = '0;
      if (!arb_if.mode) begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (arb_if.sel == SW'(i) && arb_if.in_valid[i]) begin
               w_gnt_found = 1'b1;
               w_gnt_idx   = SW'(i);
            end
         end
      end else begin
         for (int k = CHANNELS-1; k >= 0; k--) begin
            w_rr_sum = {1'b0, ptr_q} + (SW+1)'(k);
            if (w_rr_sum >= c_CH_EXT) begin
               w_rr_sum = w_rr_sum - c_CH_EXT;
            end
            w_rr_idx = w_rr_sum[SW-1:0];
            if (arb_if.in_valid[w_rr_idx]) begin
               w_gnt_found = 1'b1;
               w_gnt_idx   = w_rr_idx;
            end
         end
      end
   end

   always_comb begin
      w_gnt_oh   = '0;
      w_gnt_data = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (w_gnt_found && w_gnt_idx == SW'(i)) begin
            w_gnt_oh[i] = 1'b1;
            w_gnt_data  = arb_if.in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   assign w_load  = (!out_valid_q || arb_if.out_ready) && w_gnt_found;
   assign w_ptr_d = (w_gnt_idx == c_LAST) ? '0 : w_gnt_idx + 1'b1;

   assign arb_if.in_ready  = (w_load && !rst_i) ? w_gnt_oh : '0;
   assign arb_if.out_data  = out_data_q;
   assign arb_if.out_ch    = out_ch_q;
   assign arb_if.out_valid = out_valid_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         out_data_q  <= '0;
         out_ch_q    <= '0;
         out_valid_q <= 1'b0;
         ptr_q       <= '0;
      end else begin
         if (w_load) begin
            out_data_q  <= w_gnt_data;
            out_ch_q    <= w_gnt_idx;
            out_valid_q <= 1'b1;
            if (arb_if.mode) begin
               ptr_q <= w_ptr_d;
            end
         end else if (arb_if.out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end
endmodule
`default_nettype wire

// File: doc/arb_mux_nch.md
ARB_MUX_NCH -- requirements
Module: arb_mux_nch

Interface
REQ-001 Parameter WIDTH, default 8, data bits per channel (min 1).
REQ-002 Parameter CHANNELS, default 4, number of input channels (min 2).
REQ-003 Derived SW = max(1, clog2(CHANNELS)), the width of the channel index.
REQ-004 CLK  input  1  sole clock, rising edge.
REQ-005 RST  input  1  reset, asynchronous and active-high.
REQ-006 IN_DATA  input  CHANNELS*WIDTH  channel i data occupies bits [i*WIDTH +: WIDTH].
REQ-007 IN_VALID  input  CHANNELS  per-channel word-available flags.
REQ-008 IN_READY  output  CHANNELS  per-channel accept strobes, combinational.
REQ-009 MODE  input  1  selection mode: 0 = fixed select, 1 = round-robin.
REQ-010 SEL  input  SW  channel index used when MODE=0.
REQ-011 OUT_DATA  output  WIDTH  registered output word.
REQ-012 OUT_VALID  output  1  OUT_DATA holds an undelivered word.
REQ-013 OUT_READY  input  1  downstream consumes the word this cycle when OUT_VALID=1.
REQ-014 OUT_CH  output  SW  registered index of the channel that supplied OUT_DATA.

Function
REQ-015 The block SHALL hold a one-word output register (OUT_DATA, OUT_CH, OUT_VALID) and a round-robin pointer PTR (SW bits).
REQ-016 The load condition SHALL be LOAD = (!OUT_VALID || OUT_READY) && (grant exists).
REQ-017 MODE=0 grant: channel SEL is granted iff SEL < CHANNELS and IN_VALID[SEL]=1; otherwise there is no grant.
REQ-018 MODE=1 grant: the first i with IN_VALID[i]=1, searching PTR, PTR+1, ... with wrap modulo CHANNELS.
REQ-019 IN_READY[g] SHALL be 1 only for the granted channel g, and only in a cycle where LOAD=1; all other bits are 0.
REQ-020 On LOAD at a rising edge, the block SHALL set OUT_DATA <= channel g data, OUT_CH <= g and OUT_VALID <= 1.
REQ-021 Latency: a word accepted at edge N SHALL appear on OUT_DATA/OUT_VALID after edge N (one cycle).
REQ-022 If OUT_VALID=1, OUT_READY=1 and there is no grant, OUT_VALID SHALL go to 0; OUT_DATA and OUT_CH hold their values.
REQ-023 Drain and refill in the same cycle SHALL sustain one word per cycle with no bubble.
REQ-024 If OUT_VALID=1 and OUT_READY=0 (stall), all outputs SHALL hold and IN_READY SHALL be all zero.
REQ-025 PTR SHALL update to (g+1) mod CHANNELS only on a LOAD made in MODE=1; otherwise PTR holds.
REQ-026 PTR wrap: a grant of channel CHANNELS-1 SHALL set PTR to 0.
REQ-027 A MODE change SHALL take effect in the same cycle, SHALL not alter PTR, and SHALL not disturb a held output word.
REQ-028 Non-power-of-two CHANNELS SHALL never produce a grant, OUT_CH or PTR value >= CHANNELS.
REQ-029 Input data of non-granted channels SHALL never reach OUT_DATA.

Reset
REQ-030 While RST=1, asynchronously: OUT_VALID=0, OUT_DATA=0, OUT_CH=0, PTR=0, and IN_READY is all zero.
REQ-031 Reset mid-operation SHALL discard any held word; after RST falls, the first MODE=1 grant searches from channel 0.

Verification (WIDTH=8, CHANNELS=4)
REQ-032 MODE=0, SEL=2, IN_VALID=0100, ch2=0xA5, OUT_READY=1 -> IN_READY=0100 in the accept cycle; next cycle OUT_DATA=0xA5, OUT_CH=2, OUT_VALID=1.
REQ-033 MODE=1, IN_VALID=1111 held, OUT_READY=1 -> OUT_CH sequence 0,1,2,3,0 on consecutive cycles, OUT_VALID continuously 1.
REQ-034 Stall: OUT_VALID=1, OUT_READY=0 for 3 cycles with new input data -> OUT_DATA unchanged and IN_READY=0000 throughout; OUT_READY=1 -> the next word loads the following cycle.
REQ-035 MODE=1, PTR=3, IN_VALID=0010 -> channel 1 granted and PTR becomes 2; MODE=0, SEL=3, IN_VALID=0001 -> no grant and OUT_VALID falls after the drain.
REQ-036 Assert RST while OUT_VALID=1 and PTR=2 -> outputs zero immediately without waiting for a clock edge; after release, IN_VALID=1100 in MODE=1 -> channel 2 granted (searched from PTR=0).
REQ-037 CHANNELS=3 build, MODE=0, SEL=3 with IN_VALID=111 -> no grant ever; MODE=1 -> OUT_CH cycles 0,1,2,0 and never shows 3.
